// File: rtl/mfp_ahb_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave: transfer-type and size
// encodings, response codes and the data-phase FSM state type.
package mfp_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_8  = 3'd0;
  localparam logic [2:0] HSIZE_16 = 3'd1;
  localparam logic [2:0] HSIZE_32 = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_state_e;

endpackage

// File: rtl/mfp_ahb_sram_bank.sv
// One 8-bit byte lane of the SRAM: synchronous write, registered read.
// Ports: clk; re/raddr start a read whose result is held on rdata until the
// next re; we/waddr/wdata perform a write. Contents are never reset.
module mfp_ahb_sram_bank #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mfp_ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states, size-driven byte lanes,
// write-to-read forwarding and a two-cycle ERROR response for illegal sizes
// or misaligned addresses.
// Ports: HCLK/HRESETn clock and async active-low reset; HSEL, HADDR, HTRANS,
// HSIZE, HBURST, HWRITE, HREADY address-phase inputs; HWDATA write data;
// HREADYOUT, HRESP, HRDATA data-phase response.
module mfp_ahb_sram_slave
  import mfp_ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW = ADDR_WIDTH - 2;
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  ahb_state_e    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          wr_pend_q, wr_pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    fwd_mask_q, fwd_mask_d;
  logic [31:0]   fwd_data_q, fwd_data_d;

  logic          ready, trans_active, acc, legal, commit;
  logic [3:0]    lane_mask;
  logic [AW-1:0] acc_addr;
  logic [31:0]   ram_rdata, merged;
  logic          unused_bits;

  assign unused_bits = ^{HBURST, HADDR[31:ADDR_WIDTH]};

  assign ready    = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign acc      = HSEL & HREADY & ready & trans_active;
  assign acc_addr = HADDR[ADDR_WIDTH-1:2];
  // The final data cycle of a pending write is any cycle we report ready.
  assign commit   = ready & wr_pend_q;

  always_comb begin
    trans_active = 1'b0;
    case (HTRANS)
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
    endcase
  end

  always_comb begin
    lane_mask = '0;
    legal     = 1'b0;
    case (HSIZE)
      HSIZE_8: begin
        lane_mask = 4'b0001 << HADDR[1:0];
        legal     = 1'b1;
      end
      HSIZE_16: begin
        lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
        legal     = ~HADDR[0];
      end
      HSIZE_32: begin
        lane_mask = '1;
        legal     = (HADDR[1:0] == 2'b00);
      end
      default: begin
        lane_mask = '0;
        legal     = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (acc) begin
          if (!legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_pend_d  = rd_pend_q;
    wr_pend_d  = wr_pend_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    fwd_mask_d = fwd_mask_q;
    fwd_data_d = fwd_data_q;
    if (ready) begin
      rd_pend_d = acc & legal & ~HWRITE;
      wr_pend_d = acc & legal & HWRITE;
      if (acc) begin
        addr_d     = acc_addr;
        mask_d     = lane_mask;
        // The RAM returns pre-write data when a read hits the word being
        // committed this cycle, so remember which bytes to take from HWDATA.
        fwd_mask_d = (commit && (addr_q == acc_addr)) ? mask_q : '0;
        fwd_data_d = HWDATA;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      wr_pend_q  <= 1'b0;
      addr_q     <= '0;
      mask_q     <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      wr_pend_q  <= wr_pend_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    mfp_ahb_sram_bank #(.AW(AW)) u_bank (
      .clk   (HCLK),
      .re    (acc),
      .raddr (acc_addr),
      .we    (commit & mask_q[i]),
      .waddr (addr_q),
      .wdata (HWDATA[8*i +: 8]),
      .rdata (ram_rdata[8*i +: 8])
    );
  end

  always_comb begin
    merged = ram_rdata;
    for (int unsigned i = 0; i < 4; i++) begin
      if (fwd_mask_q[i]) merged[8*i +: 8] = fwd_data_q[8*i +: 8];
    end
  end

  assign HREADYOUT = ready;
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (ready & rd_pend_q) ? merged : '0;

endmodule
